// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Types and helpers shared by the FIFO read-side blocks.
//                rd_state_t - read-side control state (RUN / FLUSH)
//                ptr_width  - index width for a circular buffer of a depth
//                occ_width  - width able to hold 0..depth
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_t;

    // A depth-1 buffer still needs a one-bit pointer to stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_prefetch_buf
//  Description : Circular prefetch buffer between the FIFO read port and the
//                outgoing valid/ready stream. Any depth >= 1 is legal; the
//                pointers wrap explicitly at BUF_DEPTH-1.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                clear        - drop all contents (wins over wr_en/rd_en)
//                wr_en/wr_data- write one word at the tail
//                rd_en        - remove the head word
//                out_data     - head word (registered storage)
//                out_valid    - buffer not empty
//                occ          - number of stored words
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int BUF_DEPTH   = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                wr_en,
    input  logic [DATA_LENGTH-1:0]              wr_data,
    input  logic                                rd_en,
    output logic [DATA_LENGTH-1:0]              out_data,
    output logic                                out_valid,
    output logic [occ_width(BUF_DEPTH)-1:0]     occ
);

    localparam int PTR_W = ptr_width(BUF_DEPTH);
    localparam int OCC_W = occ_width(BUF_DEPTH);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_LENGTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [OCC_W-1:0]       r_occ;
    logic                   w_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // A read of an empty buffer is ignored so occ can never underflow.
    assign w_rd      = rd_en && (r_occ != '0);
    assign out_valid = (r_occ != '0);
    assign out_data  = r_mem[r_head];
    assign occ       = r_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_tail] <= wr_data;
                r_tail        <= next_ptr(r_tail);
            end
            if (w_rd) begin
                r_head <= next_ptr(r_head);
            end
            case ({wr_en, w_rd})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule : fifo_prefetch_buf
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Read-side consumer for the FIFO pop interface. Pops words
//                (data returns one cycle after pop), holds them in a small
//                prefetch buffer and re-presents them on a valid/ready stream.
//                Credits (occupancy + in-flight pop) bound the pops, so
//                out_ready never combinationally reaches pop.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                fifo_empty, fifo_data- FIFO status and dataOut
//                pop                  - pop request to the FIFO
//                out_data/out_valid/out_ready - downstream stream
//                flush                - discard buffered and in-flight data
//                words_read           - saturating count of delivered words
//                busy                 - high while flushing
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int BUF_DEPTH   = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_LENGTH-1:0] fifo_data,
    output logic                   pop,
    output logic [DATA_LENGTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [CNT_WIDTH-1:0]   words_read,
    output logic                   busy
);

    localparam int OCC_W = occ_width(BUF_DEPTH);
    localparam logic [OCC_W:0]       c_depth   = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    rd_state_t            r_state;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_words_read;

    logic [OCC_W-1:0]     w_occ;
    logic                 w_credit_ok;
    logic                 w_clear;
    logic                 w_capture;
    logic                 w_xfer;

    // A word already requested owns a buffer slot before it lands.
    assign w_credit_ok = ({1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight}) < c_depth;

    assign pop = !reset && (r_state == RUN) && !fifo_empty && w_credit_ok && !flush;

    // Entering FLUSH empties the buffer; this also drops a word landing on
    // that same edge. Words landing while in FLUSH are simply not written.
    assign w_clear   = (r_state == RUN) && flush;
    assign w_capture = r_inflight && (r_state == RUN);
    assign w_xfer    = out_valid && out_ready;

    assign words_read = r_words_read;
    assign busy       = (r_state == FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_inflight   <= 1'b0;
            r_words_read <= '0;
        end else begin
            r_inflight <= pop;
            if (w_xfer && (r_words_read != c_cnt_max)) begin
                r_words_read <= r_words_read + 1'b1;
            end
            case (r_state)
                RUN: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!r_inflight) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    fifo_prefetch_buf #(
        .DATA_LENGTH (DATA_LENGTH),
        .BUF_DEPTH   (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .wr_en     (w_capture),
        .wr_data   (fifo_data),
        .rd_en     (w_xfer),
        .out_data  (out_data),
        .out_valid (out_valid),
        .occ       (w_occ)
    );

endmodule : fifo_stream_reader
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed self-checking bench for fifo_stream_reader. A
//                default-parameter instance runs against a model FIFO; a
//                second instance with a 4-bit counter covers saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          out_ready;
    logic          flush;
    logic          fifo_empty;
    logic [DL-1:0] fifo_data = '0;
    logic          pop;
    logic [DL-1:0] out_data;
    logic          out_valid;
    logic [15:0]   words_read;
    logic          busy;

    logic          s_fifo_empty;
    logic [DL-1:0] s_fifo_data = '0;
    logic          s_pop;
    logic [DL-1:0] s_out_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic          s_flush;
    logic [3:0]    s_words_read;
    logic          s_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model FIFO: memory and write count owned by the stimulus, read pointer
    // owned by the pop process.
    logic [DL-1:0] fifo_mem [64];
    int wr_cnt = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    logic [DL-1:0] got [$];
    int s_xfer = 0;

    assign fifo_empty = (rd_ptr >= wr_cnt);

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 0;
        end else if (pop) begin
            fifo_data <= fifo_mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
            pop_cnt   <= pop_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back(out_data);
    end

    always @(posedge clk) begin
        if (reset) s_fifo_data <= '0;
        else if (s_pop) s_fifo_data <= s_fifo_data + 1'b1;
        if (!reset && s_out_valid && s_out_ready) s_xfer <= s_xfer + 1;
    end

    fifo_stream_reader #(
        .DATA_LENGTH (DL),
        .BUF_DEPTH   (3),
        .CNT_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .pop        (pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .words_read (words_read),
        .busy       (busy)
    );

    fifo_stream_reader #(
        .DATA_LENGTH (DL),
        .BUF_DEPTH   (3),
        .CNT_WIDTH   (4)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (s_fifo_empty),
        .fifo_data  (s_fifo_data),
        .pop        (s_pop),
        .out_data   (s_out_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .flush      (s_flush),
        .words_read (s_words_read),
        .busy       (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic append(input logic [DL-1:0] v);
        fifo_mem[wr_cnt[5:0]] = v;
        wr_cnt++;
    endtask

    int gbase;
    int pbase;

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        s_fifo_empty = 1'b1;
        s_out_ready = 1'b0;
        s_flush     = 1'b0;

        // Reset held 3 cycles with a non-empty FIFO.
        for (int i = 0; i < 16; i++) append(DL'(i + 1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pop",   32'(pop),        0);
            chk("rst_valid", 32'(out_valid),  0);
            chk("rst_count", 32'(words_read), 0);
        end

        // Streaming 0x01..0x10 with out_ready high.
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("stream_pop_c0", 32'(pop), 1);
        step();
        chk("stream_valid_c1", 32'(out_valid), 0);
        for (int k = 2; k <= 17; k++) begin
            step();
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_data",  32'(out_data),  32'(k - 1));
        end
        step();
        chk("stream_drained", 32'(out_valid),  0);
        chk("stream_count",   32'(words_read), 16);

        // Backpressure: exactly three pops fill the buffer.
        out_ready = 1'b0;
        pbase = pop_cnt;
        for (int i = 0; i < 6; i++) append(DL'(8'h21 + i));
        for (int i = 0; i < 6; i++) step();
        chk("bp_pops",  32'(pop_cnt - pbase),   3);
        chk("bp_pop0",  32'(pop),               0);
        chk("bp_occ",   32'(dut.u_buf.occ),     3);
        chk("bp_head",  32'(out_data),          32'h21);
        gbase = got.size();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("bp_count", 32'(got.size() - gbase), 6);
        for (int i = 0; i < 6; i++) begin
            chk("bp_order", 32'(got[gbase + i]), 32'(8'h21 + i));
        end

        // Single word then empty.
        pbase = pop_cnt;
        gbase = got.size();
        append(8'h55);
        for (int i = 0; i < 6; i++) step();
        chk("empty_pops",  32'(pop_cnt - pbase),     1);
        chk("empty_words", 32'(got.size() - gbase),  1);
        chk("empty_data",  32'(got[gbase]),          32'h55);
        chk("empty_pop0",  32'(pop),                 0);
        chk("empty_count", 32'(words_read),          23);

        // Flush with two buffered words and one in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) append(DL'(8'h61 + i));
        step();
        step();
        step();
        chk("fl_occ",      32'(dut.u_buf.occ),  2);
        chk("fl_inflight", 32'(dut.r_inflight), 1);
        flush = 1'b1;
        #1;
        chk("fl_pop_block", 32'(pop), 0);
        step();
        flush = 1'b0;
        chk("fl_busy",    32'(busy),       1);
        chk("fl_valid",   32'(out_valid),  0);
        chk("fl_pop",     32'(pop),        0);
        chk("fl_count",   32'(words_read), 23);
        step();
        chk("fl_busy_end", 32'(busy), 0);
        chk("fl_resume",   32'(pop),  1);
        gbase = got.size();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("fl_words",  32'(got.size() - gbase), 2);
        chk("fl_next0",  32'(got[gbase]),         32'h64);
        chk("fl_next1",  32'(got[gbase + 1]),     32'h65);
        chk("fl_count2", 32'(words_read),         25);

        // Saturation on the 4-bit instance, then reset mid-stream.
        s_fifo_empty = 1'b0;
        s_out_ready  = 1'b1;
        for (int i = 0; i < 60 && s_xfer < 20; i++) step();
        chk("sat_reached", 32'(s_xfer >= 20), 1);
        chk("sat_count",   32'(s_words_read), 15);
        chk("sat_valid",   32'(s_out_valid),  1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(s_out_valid),       0);
        chk("mid_rst_count", 32'(s_words_read),      0);
        chk("mid_rst_pop",   32'(s_pop),             0);
        chk("mid_rst_busy",  32'(s_busy),            0);
        chk("mid_rst_occ",   32'(dut_sat.u_buf.occ), 0);
        chk("mid_rst_data",  32'(s_out_data),        0);
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_stream_reader
`default_nettype wire
